// File: rtl/therm_temp_to_vcode.sv
// Inverse thermistor conversion: binary-searches the voltage->temperature table for the
// smallest voltage code whose temperature is at or below the target; (W+1)*(LUT_LAT+1)+1 cycles.
module therm_temp_to_vcode #(
  parameter int W       = 8,
  parameter int LUT_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] temp_target,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] v_code,
  output logic         exact,
  output logic         out_of_range,
  output logic [W-1:0] lut_addr,
  input  logic [W-1:0] lut_temp
);

  localparam int WCW = 8;
  localparam int PCW = $clog2(W + 1);
  localparam logic [WCW-1:0] WAIT_INIT = WCW'((LUT_LAT > 1) ? (LUT_LAT - 2) : 0);
  localparam logic [W-1:0] CODE_MAX = '1;
  localparam logic [W-1:0] MID_INIT = CODE_MAX >> 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CMP, S_CHECK_ISSUE, S_CHECK, S_DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   tgt, lo, hi;
  logic [PCW-1:0] probe_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           chk_phase;

  logic           le;
  logic [W-1:0]   next_lo, next_hi;
  logic [W:0]     mid_sum;

  // lut_addr holds the current probe's mid while in CMP, so it doubles as mid here.
  always_comb begin
    le      = (lut_temp <= tgt);
    next_lo = le ? lo : (lut_addr + W'(1));
    next_hi = le ? lut_addr : hi;
    mid_sum = {1'b0, next_lo} + {1'b0, next_hi};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      tgt          <= '0;
      lo           <= '0;
      hi           <= '0;
      probe_cnt    <= '0;
      wait_cnt     <= '0;
      chk_phase    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      v_code       <= '0;
      exact        <= 1'b0;
      out_of_range <= 1'b0;
      lut_addr     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            tgt       <= temp_target;
            lo        <= '0;
            hi        <= CODE_MAX;
            lut_addr  <= MID_INIT;
            probe_cnt <= '0;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE, S_CHECK_ISSUE: begin
          chk_phase <= (state == S_CHECK_ISSUE);
          wait_cnt  <= WAIT_INIT;
          if (LUT_LAT > 1)
            state <= S_WAIT;
          else
            state <= (state == S_CHECK_ISSUE) ? S_CHECK : S_CMP;
        end
        S_WAIT: begin
          if (wait_cnt == '0)
            state <= chk_phase ? S_CHECK : S_CMP;
          else
            wait_cnt <= wait_cnt - WCW'(1);
        end
        S_CMP: begin
          lo        <= next_lo;
          hi        <= next_hi;
          probe_cnt <= probe_cnt + PCW'(1);
          if (probe_cnt == PCW'(W - 1)) begin
            lut_addr <= next_lo;
            state    <= S_CHECK_ISSUE;
          end else begin
            lut_addr <= mid_sum[W:1];
            state    <= S_ISSUE;
          end
        end
        S_CHECK: begin
          v_code       <= lo;
          exact        <= (lut_temp == tgt);
          out_of_range <= (lut_temp > tgt);
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
